// File: rtl/alu_arith_pkg.sv
// rtl/alu_arith_pkg.sv - shared width, opcode strobe indices and priority encoder for the arithmetic slice
package alu_arith_pkg;

   localparam int WIDTH   = 8;
   localparam int NUM_OPS = 6;

   // Bit positions of each strobe inside the packed strobe vector
   localparam int OP_DEC = 0;
   localparam int OP_INC = 1;
   localparam int OP_ADD = 2;
   localparam int OP_SUB = 3;
   localparam int OP_CMP = 4;
   localparam int OP_NEG = 5;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_DEC,
      SEL_INC,
      SEL_ADD,
      SEL_SUB,
      SEL_CMP,
      SEL_NEG
   } op_sel_e;

   // Strobes should be one-hot; when they are not, the lowest index wins
   function automatic op_sel_e prio_encode(input logic [NUM_OPS-1:0] strobes);
      op_sel_e sel;
      sel = SEL_NONE;
      if (strobes[OP_DEC])      sel = SEL_DEC;
      else if (strobes[OP_INC]) sel = SEL_INC;
      else if (strobes[OP_ADD]) sel = SEL_ADD;
      else if (strobes[OP_SUB]) sel = SEL_SUB;
      else if (strobes[OP_CMP]) sel = SEL_CMP;
      else if (strobes[OP_NEG]) sel = SEL_NEG;
      return sel;
   endfunction

endpackage

// File: rtl/add8_ripple.sv
// rtl/add8_ripple.sv - ripple-carry adder built from chained full adders
module add8_ripple
   import alu_arith_pkg::*;
(
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic carry;

   // One full adder per bit, carry rippling from bit 0 upward
   always_comb begin
      carry = cin;
      s     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]  = x[i] ^ y[i] ^ carry;
         carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/alu_arithmetic.sv
// rtl/alu_arithmetic.sv - arithmetic ALU slice: shared adder, operand muxes, registered sum and carry
module alu_arithmetic
   import alu_arith_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec,
   input  logic             inc,
   input  logic             add,
   input  logic             sub,
   input  logic             cmp,
   input  logic             neg,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   logic [NUM_OPS-1:0] strobes;
   op_sel_e            sel;
   logic [WIDTH-1:0]   x, y, s;
   logic               cin, cout;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_q, c_d;

   assign strobes = {neg, cmp, sub, add, inc, dec};
   assign sel     = prio_encode(strobes);

   // Operand selection: every op is expressed as X + Y + cin on the one adder
   always_comb begin
      x   = a;
      y   = '0;
      cin = 1'b0;
      case (sel)
         SEL_ADD: begin y = b;              cin = 1'b0; end
         SEL_SUB,
         SEL_CMP: begin y = ~b;             cin = 1'b1; end
         SEL_INC: begin y = '0;             cin = 1'b1; end
         SEL_DEC: begin y = {WIDTH{1'b1}};  cin = 1'b0; end
         SEL_NEG: begin x = '0; y = ~a;     cin = 1'b1; end
         default: ;
      endcase
   end

   add8_ripple u_adder (
      .x    (x),
      .y    (y),
      .cin  (cin),
      .s    (s),
      .cout (cout)
   );

   // Next-state: cmp only touches the carry, no strobe holds both registers
   always_comb begin
      sum_d = sum_q;
      c_d   = c_q;
      case (sel)
         SEL_NONE: ;
         SEL_CMP:  c_d = cout;
         default: begin
            sum_d = s;
            c_d   = cout;
         end
      endcase
   end

   // Output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         c_q   <= 1'b0;
      end else begin
         sum_q <= sum_d;
         c_q   <= c_d;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_q;

endmodule

// File: tb/tb_alu_arithmetic.sv
// tb/tb_alu_arithmetic.sv - directed and randomised self-checking bench for alu_arithmetic
module tb_alu_arithmetic;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_DEC  = 6'b000001;
   localparam logic [5:0] S_INC  = 6'b000010;
   localparam logic [5:0] S_ADD  = 6'b000100;
   localparam logic [5:0] S_SUB  = 6'b001000;
   localparam logic [5:0] S_CMP  = 6'b010000;
   localparam logic [5:0] S_NEG  = 6'b100000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dec, inc, add, sub, cmp, neg;
   logic [7:0] a, b;
   logic [7:0] sum;
   logic       c_out;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_arithmetic dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dec   (dec),
      .inc   (inc),
      .add   (add),
      .sub   (sub),
      .cmp   (cmp),
      .neg   (neg),
      .a     (a),
      .b     (b),
      .sum   (sum),
      .c_out (c_out)
   );

   task automatic drive(input logic [5:0] ops, input logic [7:0] av, input logic [7:0] bv);
      {neg, cmp, sub, add, inc, dec} = ops;
      a = av;
      b = bv;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(S_ADD, 8'h12, 8'h34);
      #2;
      vectors++;
      if (sum !== 8'h00 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_initial: sum=%h c=%b expected sum=00 c=0", sum, c_out);
      end
      tick;
      tick;
      vectors++;
      if (sum !== 8'h00 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_held: sum=%h c=%b expected sum=00 c=0", sum, c_out);
      end
      drive(S_NONE, 8'h00, 8'h00);
      rst_n = 1'b1;
      tick;
      vectors++;
      if (sum !== 8'h00 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_idle: sum=%h c=%b expected sum=00 c=0", sum, c_out);
      end
   endtask

   task automatic test_basic_ops;
      logic [5:0] ops   [6];
      logic [7:0] exp_s [6];
      logic       exp_c [6];
      ops   = '{S_NEG, S_CMP, S_SUB, S_ADD, S_INC, S_DEC};
      exp_s = '{8'h56, 8'h56, 8'hD5, 8'h7F, 8'hAB, 8'hA9};
      exp_c = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
      for (int i = 0; i < 6; i++) begin
         drive(ops[i], 8'hAA, 8'hD5);
         tick;
         vectors++;
         if (sum !== exp_s[i] || c_out !== exp_c[i]) begin
            miscompares++;
            $display("FAIL basic_op[%0d] ops=%b: sum=%h c=%b expected sum=%h c=%b",
                     i, ops[i], sum, c_out, exp_s[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_boundaries;
      logic [5:0] ops   [8];
      logic [7:0] av    [8];
      logic [7:0] bv    [8];
      logic [7:0] exp_s [8];
      logic       exp_c [8];
      ops   = '{S_ADD, S_DEC, S_INC, S_NEG, S_NEG, S_SUB, S_NEG, S_CMP};
      av    = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h3C, 8'h80, 8'h10};
      bv    = '{8'h01, 8'h77, 8'h55, 8'hAA, 8'h00, 8'h3C, 8'h00, 8'h20};
      exp_s = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 8'h80};
      exp_c = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
      for (int i = 0; i < 8; i++) begin
         drive(ops[i], av[i], bv[i]);
         tick;
         vectors++;
         if (sum !== exp_s[i] || c_out !== exp_c[i]) begin
            miscompares++;
            $display("FAIL boundary[%0d] ops=%b a=%h b=%h: sum=%h c=%b expected sum=%h c=%b",
                     i, ops[i], av[i], bv[i], sum, c_out, exp_s[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_priority_hold;
      drive(S_ADD | S_SUB, 8'h05, 8'h03);
      tick;
      vectors++;
      if (sum !== 8'h08 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL priority_add_sub: sum=%h c=%b expected sum=08 c=0", sum, c_out);
      end
      drive(S_DEC | S_NEG, 8'h40, 8'h00);
      tick;
      vectors++;
      if (sum !== 8'h3F || c_out !== 1'b1) begin
         miscompares++;
         $display("FAIL priority_dec_neg: sum=%h c=%b expected sum=3F c=1", sum, c_out);
      end
      drive(S_ADD, 8'h05, 8'h03);
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(S_NONE, 8'hFF - 8'(i), 8'h01 + 8'(i));
         tick;
         vectors++;
         if (sum !== 8'h08 || c_out !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold[%0d]: sum=%h c=%b expected sum=08 c=0", i, sum, c_out);
         end
      end
   endtask

   task automatic test_async_reset;
      drive(S_ADD, 8'hFF, 8'hFF);
      tick;
      vectors++;
      if (sum !== 8'hFE || c_out !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_add: sum=%h c=%b expected sum=FE c=1", sum, c_out);
      end
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (sum !== 8'h00 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_immediate: sum=%h c=%b expected sum=00 c=0", sum, c_out);
      end
      tick;
      drive(S_INC, 8'h00, 8'h00);
      rst_n = 1'b1;
      tick;
      vectors++;
      if (sum !== 8'h01 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_inc: sum=%h c=%b expected sum=01 c=0", sum, c_out);
      end
   endtask

   task automatic test_random;
      logic [7:0] m_s;
      logic       m_c;
      logic [7:0] av, bv;
      logic [5:0] ops;
      int         k;
      m_s = 8'h01;
      m_c = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         k  = $urandom_range(0, 6);
         av = 8'($urandom);
         bv = 8'($urandom);
         ops = (k == 6) ? S_NONE : (6'b000001 << k);
         drive(ops, av, bv);
         tick;
         case (k)
            0: begin m_s = av - 8'h01; m_c = (av != 8'h00); end
            1: begin m_s = av + 8'h01; m_c = (av == 8'hFF); end
            2: {m_c, m_s} = {1'b0, av} + {1'b0, bv};
            3: begin m_s = av - bv; m_c = (av >= bv); end
            4: m_c = (av >= bv);
            5: begin m_s = 8'h00 - av; m_c = (av == 8'h00); end
            default: ;
         endcase
         vectors++;
         if (sum !== m_s || c_out !== m_c) begin
            miscompares++;
            $display("FAIL random[%0d] ops=%b a=%h b=%h: sum=%h c=%b expected sum=%h c=%b",
                     n, ops, av, bv, sum, c_out, m_s, m_c);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic_ops;
      test_boundaries;
      test_priority_hold;
      test_async_reset;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
